// File: rtl/stepper_move_ctrl.sv
// Move sequencer for the stepper phase FSM: start/busy command handshake, step_tick pacing, position tracking, abort.
// Optional build macro STEP_RAMP_EN: the first two step intervals of each move last 2P cycles.
module stepper_move_ctrl #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8,
  parameter int POS_W = 8
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             start,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             step_tick,
  output logic             Sin,
  output logic [POS_W-1:0] pos,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] per_q, per_n;    // latched effective period minus one
  logic             ramp_q, ramp_n;  // next reload uses the long interval
  logic             busy_n, done_n, tick_n, sin_n;
  logic [POS_W-1:0] pos_n;
  logic [CNT_W-1:0] rem_n;
  logic [DIV_W-1:0] cmd_pm1;

  // Reload value for a 2P interval: 2P-1 == {P-1, 1}, saturating at all-ones.
  function automatic logic [DIV_W-1:0] long_reload(input logic [DIV_W-1:0] pm1);
`ifdef STEP_RAMP_EN
    if (pm1[DIV_W-1])
      return '1;
    else
      return {pm1[DIV_W-2:0], 1'b1};
`else
    return pm1;
`endif
  endfunction

  always_comb begin
    cmd_pm1 = (period == '0) ? '0 : period - DIV_W'(1);
  end

  always_comb begin
    state_n = state;
    div_n   = div_q;
    per_n   = per_q;
    ramp_n  = ramp_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    tick_n  = 1'b0;
    sin_n   = Sin;
    pos_n   = pos;
    rem_n   = remaining;
    case (state)
      IDLE: begin
        if (start) begin
          if (steps != '0) begin
            per_n   = cmd_pm1;
            div_n   = long_reload(cmd_pm1);
            ramp_n  = 1'b1;
            sin_n   = dir_in;
            rem_n   = steps;
            busy_n  = 1'b1;
            state_n = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        busy_n = 1'b1;
        // Abort wins over a tick falling due on the same edge.
        if (abort) begin
          busy_n  = 1'b0;
          state_n = FIN;
        end else if (div_q == '0) begin
          tick_n = 1'b1;
          rem_n  = remaining - CNT_W'(1);
          pos_n  = Sin ? pos + POS_W'(1) : pos - POS_W'(1);
          div_n  = ramp_q ? long_reload(per_q) : per_q;
          ramp_n = 1'b0;
          if (remaining == CNT_W'(1)) begin
            busy_n  = 1'b0;
            state_n = FIN;
          end
        end else begin
          div_n = div_q - DIV_W'(1);
        end
      end
      FIN: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      state     <= IDLE;
      div_q     <= '0;
      per_q     <= '0;
      ramp_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_tick <= 1'b0;
      Sin       <= 1'b0;
      pos       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      div_q     <= div_n;
      per_q     <= per_n;
      ramp_q    <= ramp_n;
      busy      <= busy_n;
      done      <= done_n;
      step_tick <= tick_n;
      Sin       <= sin_n;
      pos       <= pos_n;
      remaining <= rem_n;
    end
  end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl: directed and random moves against a tick-schedule reference model.
module tb_stepper_move_ctrl;

  logic       CP = 1'b0;
  logic       CR;
  logic       start;
  logic       dir_in;
  logic [7:0] steps;
  logic [15:0] period;
  logic       abort;
  logic       busy, done, step_tick, Sin;
  logic [7:0] pos;
  logic [7:0] remaining;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [7:0] model_pos = '0;
  logic [7:0] model_rem = '0;
  logic       model_sin = 1'b0;

  stepper_move_ctrl #(.DIV_W(16), .CNT_W(8), .POS_W(8)) dut (
    .CP(CP), .CR(CR), .start(start), .dir_in(dir_in), .steps(steps),
    .period(period), .abort(abort), .busy(busy), .done(done),
    .step_tick(step_tick), .Sin(Sin), .pos(pos), .remaining(remaining)
  );

  always #5 CP = ~CP;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the accepting edge to the edge that issues tick number i.
  function automatic int unsigned tick_time(input int unsigned per, input int unsigned i);
    int unsigned p = (per == 0) ? 1 : per;
    int unsigned s = 0;
    for (int unsigned m = 1; m <= i; m++) begin
      int unsigned len = p;
`ifdef STEP_RAMP_EN
      if (m <= 2) len = (2 * p > 65536) ? 65536 : 2 * p;
`endif
      s += len;
    end
    return s;
  endfunction

  task automatic check_all(input string tag, input logic eb, input logic ed, input logic et,
                           input logic es, input logic [7:0] ep, input logic [7:0] er);
    check({tag, ".busy"}, busy, eb);
    check({tag, ".done"}, done, ed);
    check({tag, ".tick"}, step_tick, et);
    check({tag, ".Sin"}, Sin, es);
    check({tag, ".pos"}, pos, ep);
    check({tag, ".rem"}, remaining, er);
  endtask

  // abort_at = 0: no abort; otherwise abort is sampled at accepting edge + abort_at.
  task automatic do_move(input logic d, input int unsigned n, input int unsigned per,
                         input int unsigned abort_at, input string tag);
    int unsigned end_edge;
    int unsigned issued;
    logic        exp_tick;
    logic [7:0]  exp_pos, exp_rem;
    logic        exp_sin;
    end_edge = (n == 0) ? 0 : ((abort_at != 0) ? abort_at : tick_time(per, n));
    @(negedge CP);
    start = 1'b1; dir_in = d; steps = 8'(n); period = 16'(per); abort = 1'b0;
    for (int unsigned j = 0; j <= end_edge + 3; j++) begin
      @(negedge CP);
      issued   = 0;
      exp_tick = 1'b0;
      for (int unsigned i = 1; i <= n; i++) begin
        int unsigned t = tick_time(per, i);
        if (t <= j && (abort_at == 0 || t < abort_at)) issued++;
        if (t == j && (abort_at == 0 || t < abort_at)) exp_tick = 1'b1;
      end
      exp_pos = d ? model_pos + 8'(issued) : model_pos - 8'(issued);
      exp_rem = (n == 0) ? model_rem : 8'(n - issued);
      exp_sin = (n == 0) ? model_sin : d;
      check_all(tag, (n != 0) && (j < end_edge),
                (n == 0) ? (j == 0) : (j == end_edge + 1),
                exp_tick, exp_sin, exp_pos, exp_rem);
      // Junk commands while RUN/FIN must be ignored.
      if (n != 0 && j + 1 <= end_edge + 1) begin
        start  = 1'($urandom_range(0, 1));
        dir_in = 1'($urandom_range(0, 1));
        steps  = 8'($urandom_range(0, 255));
        period = 16'($urandom_range(0, 65535));
      end else begin
        start = 1'b0;
      end
      if (abort_at != 0 && j + 1 == abort_at)
        abort = 1'b1;
      else if (n != 0 && j + 1 == end_edge + 1)
        abort = 1'($urandom_range(0, 1));
      else
        abort = 1'b0;
      if (j == end_edge + 3) begin
        model_pos = exp_pos;
        model_rem = exp_rem;
        model_sin = exp_sin;
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge CP);
    CR = 1'b1; start = 1'b0; abort = 1'b0;
    @(negedge CP);
    CR = 1'b0;
    model_pos = '0; model_rem = '0; model_sin = 1'b0;
    check_all("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    int unsigned rn, rp, ra;
    CR = 1'b1; start = 1'b1; dir_in = 1'b1; steps = 8'd5; period = 16'd2; abort = 1'b0;
    repeat (2) begin
      @(negedge CP);
      check_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    CR = 1'b0; start = 1'b0;

    do_move(1'b1, 3, 4, 0, "fwd");
    check("fwd.final_pos", pos, 8'd3);
    reset_dut();
    do_move(1'b0, 2, 0, 0, "rev_wrap");
    check("rev_wrap.final_pos", pos, 8'hFE);
    do_move(1'b1, 0, 7, 0, "zero");
    reset_dut();
    do_move(1'b1, 10, 3, tick_time(3, 4), "abort");
    check("abort.rem", remaining, 8'd7);
    check("abort.pos", pos, 8'd3);

    for (int k = 0; k < 20; k++) begin
      rn = $urandom_range(0, 6);
      rp = $urandom_range(0, 5);
      ra = 0;
      if (rn != 0 && $urandom_range(0, 2) == 0) ra = $urandom_range(1, tick_time(rp, rn));
      do_move(1'($urandom_range(0, 1)), rn, rp, ra, "rand");
    end

    // Reset during RUN after two ticks.
    @(negedge CP);
    start = 1'b1; dir_in = 1'b1; steps = 8'd5; period = 16'd2; abort = 1'b0;
    for (int unsigned j = 0; j <= tick_time(2, 2); j++) begin
      @(negedge CP);
      start = 1'b0;
    end
    check("midrst.tick_before", step_tick, 1'b1);
    CR = 1'b1;
    @(negedge CP);
    CR = 1'b0;
    check_all("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int j = 0; j < 12; j++) begin
      @(negedge CP);
      check("midrst.quiet_tick", step_tick, 1'b0);
      check("midrst.quiet_done", done, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_move_ctrl.md
Name: stepper_move_ctrl

Overview:
Move sequencer for the 3-bit stepper phase FSM. It accepts a move command (direction, step count, step period) through a start/busy handshake. It then emits one-cycle step_tick pulses at a programmable rate, plus a stable direction level Sin, for the stepper FSM's clock-enable and direction inputs. It also tracks absolute position and steps remaining, and supports abort.

Parameters:
DIV_W, 16, width of step-period divider (period in CP cycles)
CNT_W, 8, width of step-count command and remaining counter
POS_W, 8, width of wrap-around position counter

Ports:
CP  input  1  system clock, all logic on rising edge
CR  input  1  synchronous active-high reset
start  input  1  command strobe, sampled only in IDLE
dir_in  input  1  move direction; 1 = forward (pos increments), 0 = reverse
steps  input  CNT_W  number of steps to issue
period  input  DIV_W  CP cycles between steps; 0 treated as 1
abort  input  1  terminate current move
busy  output  1  move in progress
done  output  1  one-cycle completion/abort pulse
step_tick  output  1  one-cycle step pulse to stepper FSM
Sin  output  1  direction level to stepper FSM
pos  output  POS_W  absolute position, modulo 2^POS_W
remaining  output  CNT_W  steps not yet issued

Behaviour:
- Reset: CR=1 at an edge overrides all inputs. Next cycle: state IDLE, busy=0, done=0, step_tick=0, Sin=0, pos=0, remaining=0, divider=0.
- Reset mid-move: the move is discarded, no done pulse, pos cleared.
- States: IDLE, RUN, FIN.
- IDLE, start=1, steps!=0 (edge k):
  - latch dir/steps/effective period P (P=max(period,1)); Sin=dir_in, remaining=steps, divider=P-1, busy=1, go RUN.
- IDLE, start=1, steps==0: no tick, busy stays 0, done=1 for the cycle after edge k; stay IDLE.
- RUN, each edge, divider!=0: decrement divider.
- RUN, divider==0:
  - step_tick=1 for exactly one cycle.
  - remaining decrements.
  - pos increments (Sin=1) or decrements (Sin=0), wrapping modulo 2^POS_W.
  - divider reloads P-1.
- Tick timing: first step_tick is high in the cycle after edge k+P. Later ticks follow every P cycles. P=1 gives a tick every cycle.
- Last tick (remaining goes 1→0): go FIN. In FIN, done=1 and busy=0 for one cycle, then IDLE.
  - Total: busy high for steps*P cycles; done follows the last tick cycle immediately.
- abort=1 in RUN: has priority over a coincident tick. No tick is issued at that edge; go FIN (done pulse).
  - remaining holds the unissued count until the next accepted start. pos holds.
- abort in IDLE/FIN: ignored.
- start while busy or in FIN: ignored. Latched command is unaffected.
- Sin and latched period are stable for the whole move. Input changes mid-move have no effect.
- Outputs are registered; no combinational input→output paths.

Optional Feature:
STEP_RAMP_EN. When defined, the first two step intervals of each move use 2P cycles (divider loaded 2P-1; saturate at 2^DIV_W-1). All later intervals use P; moves shorter than 3 steps use 2P throughout. When undefined, every interval is P. Position, done and abort rules are identical in both builds.

Test Plan:
- Reset: hold CR=1 two cycles with start=1 → busy=0, done=0, step_tick=0, pos=0, remaining=0, no state change.
- Forward move: start, dir_in=1, steps=3, period=4 at edge 10:
  - step_tick high in cycles after edges 14, 18, 22.
  - done high after edge 23; busy high edges 10–22.
  - pos=3, remaining=0.
  - With STEP_RAMP_EN: ticks after edges 18, 26, 30.
- Reverse wrap: from pos=0, dir_in=0, steps=2, period=0 → ticks on two consecutive cycles, pos=0xFE, done one cycle later.
- Zero steps: start with steps=0 → done single pulse, no step_tick, busy never 1.
- Abort: steps=10, period=3, assert abort in the same cycle as the 4th tick's divider==0 → only 3 ticks, done pulse, remaining=7, pos=3. A start issued while busy earlier in the move had no effect.
- Reset mid-move: CR=1 during RUN after 2 ticks → next cycle busy=0, pos=0, no done pulse, no further ticks.
